// File: rtl/fabric_temporal_pe_pipelined.sv
// Tag-dispatched temporal PE with a LATENCY-deep stallable result pipeline.
// The incoming tag on port 0 selects an instruction slot. The slot says where
// each operand comes from (a port or a register FIFO) and where each result
// goes (an output port or a register FIFO).
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. in_ready is asserted only on the ports that the firing instruction
// consumes. out_valid does not depend on out_ready, and out_data holds steady
// while the output is stalled.
module fabric_temporal_pe_pipelined #(
    parameter int NUM_INPUTS       = 2,
    parameter int NUM_OUTPUTS      = 1,
    parameter int DATA_WIDTH       = 32,
    parameter int TAG_WIDTH        = 4,
    parameter int NUM_FU_TYPES     = 4,
    parameter int NUM_REGISTERS    = 2,
    parameter int REG_FIFO_DEPTH   = 2,
    parameter int NUM_INSTRUCTIONS = 4,
    parameter int LATENCY          = 2,
    localparam int REG_IDX_W  = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1,
    localparam int FU_SEL_W   = 2,
    localparam int RESULT_W   = 1 + REG_IDX_W + TAG_WIDTH,
    localparam int OPERAND_W  = 1 + REG_IDX_W,
    localparam int INSN_WIDTH = NUM_OUTPUTS * RESULT_W + NUM_INPUTS * OPERAND_W
                                + FU_SEL_W + TAG_WIDTH + 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_INPUTS-1:0]                         in_valid,
    output logic [NUM_INPUTS-1:0]                         in_ready,
    input  logic [NUM_INPUTS*(DATA_WIDTH+TAG_WIDTH)-1:0]  in_data,
    output logic [NUM_OUTPUTS-1:0]                        out_valid,
    input  logic [NUM_OUTPUTS-1:0]                        out_ready,
    output logic [NUM_OUTPUTS*(DATA_WIDTH+TAG_WIDTH)-1:0] out_data,
    input  logic [NUM_INSTRUCTIONS*INSN_WIDTH-1:0]        cfg_data,
    output logic                                          busy,
    output logic                                          error_valid,
    output logic [15:0]                                   error_code
);

    // Error codes shared with the single-cycle temporal PE
    localparam logic [15:0] CFG_TEMPORAL_PE_DUP_TAG         = 16'd10;
    localparam logic [15:0] CFG_TEMPORAL_PE_ILLEGAL_REG     = 16'd11;
    localparam logic [15:0] CFG_TEMPORAL_PE_REG_TAG_NONZERO = 16'd12;
    localparam logic [15:0] RT_TEMPORAL_PE_NO_MATCH         = 16'd262;

    localparam int  PW        = DATA_WIDTH + TAG_WIDTH;
    localparam int  DST_W     = NUM_OUTPUTS * RESULT_W;
    localparam int  OP_OFF    = DST_W;
    localparam int  FU_OFF    = OP_OFF + NUM_INPUTS * OPERAND_W;
    localparam int  TAG_OFF   = FU_OFF + FU_SEL_W;
    localparam int  VALID_OFF = TAG_OFF + TAG_WIDTH;
    localparam int  SEL_W     = (NUM_INSTRUCTIONS > 1) ? $clog2(NUM_INSTRUCTIONS) : 1;
    localparam bit  HAS_REGS  = (NUM_REGISTERS > 0);
    // Register index space is padded to a power of two. Slots that do not exist
    // read as empty and full, so an illegal index stalls instead of corrupting state.
    localparam int  REG_SLOTS = 1 << REG_IDX_W;
    localparam int  PTR_W     = (REG_FIFO_DEPTH > 1) ? $clog2(REG_FIFO_DEPTH) : 1;
    localparam int  CNT_W     = $clog2(REG_FIFO_DEPTH + 1);

    // Decoded instruction slots
    logic                  w_slot_valid [NUM_INSTRUCTIONS];
    logic [TAG_WIDTH-1:0]  w_slot_tag   [NUM_INSTRUCTIONS];
    logic [FU_SEL_W-1:0]   w_slot_fu    [NUM_INSTRUCTIONS];
    logic [DST_W-1:0]      w_slot_dst   [NUM_INSTRUCTIONS];
    logic                  w_op_isreg   [NUM_INSTRUCTIONS][NUM_INPUTS];
    logic [REG_IDX_W-1:0]  w_op_idx     [NUM_INSTRUCTIONS][NUM_INPUTS];

    // Issue side
    logic                  w_match;
    logic [SEL_W-1:0]      w_sel;
    logic                  w_ops_ok;
    logic [NUM_INPUTS-1:0] w_consume;
    logic [REG_SLOTS-1:0]  w_pop_req;
    logic [REG_SLOTS-1:0]  w_pop;
    logic [DATA_WIDTH-1:0] w_op0;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_fu_res;
    logic                  w_fire;

    // Pipeline
    logic [LATENCY-1:0]    r_v;
    logic [DATA_WIDTH-1:0] r_res [LATENCY];
    logic [DST_W-1:0]      r_dst [LATENCY];
    logic                  w_retire;
    logic                  w_shift;
    logic                  w_s0_accept;
    logic [REG_SLOTS-1:0]  w_push_req;
    logic [REG_SLOTS-1:0]  w_push;

    // Register FIFO status
    logic [REG_SLOTS-1:0]  w_fifo_empty;
    logic [REG_SLOTS-1:0]  w_fifo_full;
    logic [DATA_WIDTH-1:0] w_fifo_head [REG_SLOTS];

    // Errors
    logic                  w_err_any;
    logic [15:0]           w_err_code;
    logic                  r_err_v;
    logic [15:0]           r_err_code;

    for (genvar s = 0; s < NUM_INSTRUCTIONS; s++) begin : g_slot
        localparam int B = s * INSN_WIDTH;
        assign w_slot_valid[s] = cfg_data[B + VALID_OFF];
        assign w_slot_tag[s]   = cfg_data[B + TAG_OFF +: TAG_WIDTH];
        assign w_slot_fu[s]    = cfg_data[B + FU_OFF +: FU_SEL_W];
        assign w_slot_dst[s]   = cfg_data[B +: DST_W];
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_op
            localparam int OB = B + OP_OFF + i * OPERAND_W;
            assign w_op_idx[s][i]   = cfg_data[OB +: REG_IDX_W];
            // Operand 0 always comes from port 0
            assign w_op_isreg[s][i] = HAS_REGS && (i != 0) && cfg_data[OB + REG_IDX_W];
        end
    end

    // Tag match: the highest matching slot wins
    always_comb begin
        w_match = 1'b0;
        w_sel   = '0;
        for (int s = 0; s < NUM_INSTRUCTIONS; s++) begin
            if (w_slot_valid[s] && (w_slot_tag[s] == in_data[DATA_WIDTH +: TAG_WIDTH])) begin
                w_match = 1'b1;
                w_sel   = SEL_W'(s);
            end
        end
    end

    // Operand availability, consumed ports, FIFO pops and operand values
    always_comb begin
        w_ops_ok     = 1'b1;
        w_consume    = '0;
        w_consume[0] = 1'b1;
        w_pop_req    = '0;
        w_op0        = in_data[DATA_WIDTH-1:0];
        w_op1        = '0;
        for (int i = 1; i < NUM_INPUTS; i++) begin
            if (w_op_isreg[w_sel][i]) begin
                if (w_fifo_empty[w_op_idx[w_sel][i]]) w_ops_ok = 1'b0;
                w_pop_req[w_op_idx[w_sel][i]] = 1'b1;
                if (i == 1) w_op1 = w_fifo_head[w_op_idx[w_sel][i]];
            end else begin
                if (!in_valid[i]) w_ops_ok = 1'b0;
                w_consume[i] = 1'b1;
                if (i == 1) w_op1 = in_data[i*PW +: DATA_WIDTH];
            end
        end
    end

    // Fire gating; rst_n is included so that in_ready is low for the whole reset
    assign w_fire   = rst_n && in_valid[0] && w_match && w_ops_ok && w_s0_accept;
    assign in_ready = w_fire ? w_consume : '0;
    assign w_pop    = w_fire ? w_pop_req : '0;

    // Built-in FU set; an op that is not enabled passes op0 through
    always_comb begin
        w_fu_res = w_op0;
        if (int'(w_slot_fu[w_sel]) < NUM_FU_TYPES) begin
            case (w_slot_fu[w_sel])
                2'd0:    w_fu_res = w_op0 + w_op1;
                2'd1:    w_fu_res = w_op0 - w_op1;
                2'd2:    w_fu_res = w_op0 & w_op1;
                default: w_fu_res = w_op0 ^ w_op1;
            endcase
        end
    end

    // Last-stage routing: output valids, retire condition, register pushes
    always_comb begin
        logic                 v_ok;
        logic [RESULT_W-1:0]  v_dst;
        logic [REG_IDX_W-1:0] v_idx;
        v_ok       = 1'b1;
        v_dst      = '0;
        v_idx      = '0;
        w_push_req = '0;
        out_valid  = '0;
        out_data   = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            v_dst = r_dst[LATENCY-1][o*RESULT_W +: RESULT_W];
            v_idx = v_dst[TAG_WIDTH +: REG_IDX_W];
            if (HAS_REGS && v_dst[RESULT_W-1]) begin
                if (w_fifo_full[v_idx]) v_ok = 1'b0;
                w_push_req[v_idx] = 1'b1;
            end else begin
                if (!out_ready[o]) v_ok = 1'b0;
                out_valid[o] = r_v[LATENCY-1];
            end
            out_data[o*PW +: PW] = {v_dst[TAG_WIDTH-1:0], r_res[LATENCY-1]};
        end
        w_retire = r_v[LATENCY-1] && v_ok;
        w_push   = w_retire ? w_push_req : '0;
    end

    // The whole pipe moves together. Stage 0 may also fill in place while the
    // pipe is frozen, but bubbles further down are never squeezed out.
    assign w_shift     = !r_v[LATENCY-1] || w_retire;
    assign w_s0_accept = w_shift || !r_v[0];

    // Pipeline stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_res[k] <= '0;
                r_dst[k] <= '0;
            end
        end else begin
            if (w_shift) begin
                for (int k = LATENCY - 1; k > 0; k--) begin
                    r_v[k]   <= r_v[k-1];
                    r_res[k] <= r_res[k-1];
                    r_dst[k] <= r_dst[k-1];
                end
            end
            if (w_s0_accept) begin
                r_v[0] <= w_fire;
                if (w_fire) begin
                    r_res[0] <= w_fu_res;
                    r_dst[0] <= w_slot_dst[w_sel];
                end
            end
        end
    end

    for (genvar r = 0; r < REG_SLOTS; r++) begin : g_reg
        if (r < NUM_REGISTERS) begin : g_fifo
            logic [DATA_WIDTH-1:0] r_mem [REG_FIFO_DEPTH];
            logic [PTR_W-1:0]      r_rd_ptr;
            logic [PTR_W-1:0]      r_wr_ptr;
            logic [CNT_W-1:0]      r_count;

            // Register FIFO. The push is gated by "not full" and the pop by
            // "not empty", both taken before this cycle's update, so there is no bypass.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                    for (int d = 0; d < REG_FIFO_DEPTH; d++) r_mem[d] <= '0;
                end else begin
                    if (w_push[r]) begin
                        r_mem[r_wr_ptr] <= r_res[LATENCY-1];
                        r_wr_ptr <= (r_wr_ptr == PTR_W'(REG_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                    end
                    if (w_pop[r]) begin
                        r_rd_ptr <= (r_rd_ptr == PTR_W'(REG_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                    end
                    case ({w_push[r], w_pop[r]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign w_fifo_empty[r] = (r_count == '0);
            assign w_fifo_full[r]  = (r_count == CNT_W'(REG_FIFO_DEPTH));
            assign w_fifo_head[r]  = r_mem[r_rd_ptr];
        end else begin : g_none
            assign w_fifo_empty[r] = 1'b1;
            assign w_fifo_full[r]  = 1'b1;
            assign w_fifo_head[r]  = '0;
        end
    end

    assign busy = (|r_v) || !(&w_fifo_empty);

    // Error detection: the lowest code takes priority
    always_comb begin
        logic                 v_dup;
        logic                 v_ill;
        logic                 v_rtag;
        logic [RESULT_W-1:0]  v_rd;
        v_dup  = 1'b0;
        v_ill  = 1'b0;
        v_rtag = 1'b0;
        v_rd   = '0;
        for (int s = 0; s < NUM_INSTRUCTIONS; s++) begin
            for (int t = s + 1; t < NUM_INSTRUCTIONS; t++) begin
                if (w_slot_valid[s] && w_slot_valid[t] && (w_slot_tag[s] == w_slot_tag[t]))
                    v_dup = 1'b1;
            end
            if (w_slot_valid[s]) begin
                for (int i = 1; i < NUM_INPUTS; i++) begin
                    if (w_op_isreg[s][i] && (int'(w_op_idx[s][i]) >= NUM_REGISTERS)) v_ill = 1'b1;
                end
                for (int o = 0; o < NUM_OUTPUTS; o++) begin
                    v_rd = w_slot_dst[s][o*RESULT_W +: RESULT_W];
                    if (HAS_REGS && v_rd[RESULT_W-1]) begin
                        if (int'(v_rd[TAG_WIDTH +: REG_IDX_W]) >= NUM_REGISTERS) v_ill = 1'b1;
                        if (v_rd[TAG_WIDTH-1:0] != '0) v_rtag = 1'b1;
                    end
                end
            end
        end
        w_err_any  = 1'b1;
        w_err_code = '0;
        if (v_dup)                         w_err_code = CFG_TEMPORAL_PE_DUP_TAG;
        else if (v_ill)                    w_err_code = CFG_TEMPORAL_PE_ILLEGAL_REG;
        else if (v_rtag)                   w_err_code = CFG_TEMPORAL_PE_REG_TAG_NONZERO;
        else if (in_valid[0] && !w_match)  w_err_code = RT_TEMPORAL_PE_NO_MATCH;
        else                               w_err_any  = 1'b0;
    end

    // Sticky first-error latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_v    <= 1'b0;
            r_err_code <= '0;
        end else if (!r_err_v && w_err_any) begin
            r_err_v    <= 1'b1;
            r_err_code <= w_err_code;
        end
    end

    assign error_valid = r_err_v;
    assign error_code  = r_err_code;

endmodule

// File: tb/tb_fabric_temporal_pe_pipelined.sv
// Directed bench for fabric_temporal_pe_pipelined with the default parameters.
// Instruction: {valid, tag[4], fu[2], op1{is_reg,idx}, op0{is_reg,idx}, res{is_reg,idx,tag[4]}}.
module tb_fabric_temporal_pe_pipelined;

    localparam logic [15:0] E_DUP     = 16'd10;
    localparam logic [15:0] E_REG_TAG = 16'd12;
    localparam logic [15:0] E_NOMATCH = 16'd262;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [71:0] in_data;
    logic [0:0]  out_valid;
    logic [0:0]  out_ready;
    logic [35:0] out_data;
    logic [67:0] cfg_data;
    logic        busy;
    logic        error_valid;
    logic [15:0] error_code;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rtag;
        logic [31:0] res;
    } vec_t;
    vec_t vecs[7];

    fabric_temporal_pe_pipelined dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_data(cfg_data), .busy(busy),
        .error_valid(error_valid), .error_code(error_code)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic v, input logic [3:0] tag, input logic [1:0] fu,
                                       input logic op1_reg, input logic op1_idx,
                                       input logic res_reg, input logic res_idx, input logic [3:0] rtag);
        mk = {v, tag, fu, op1_reg, op1_idx, 2'b00, res_reg, res_idx, rtag};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_base();
        cfg_data = {mk(1, 4'd4, 2'd3, 0, 0, 0, 0, 4'd11), mk(1, 4'd3, 2'd2, 0, 0, 0, 0, 4'd10),
                    mk(1, 4'd2, 2'd1, 0, 0, 0, 0, 4'd9),  mk(1, 4'd1, 2'd0, 0, 0, 0, 0, 4'd5)};
    endtask

    // slot0 tag1: add, result to reg0. slot1 tag2: sub with op1 from reg0, result to port with tag 7.
    task automatic cfg_reg();
        cfg_data = {17'd0, 17'd0, mk(1, 4'd2, 2'd1, 1, 0, 0, 0, 4'd7), mk(1, 4'd1, 2'd0, 0, 0, 1, 0, 4'd0)};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_data  = {4'h0, b, tag, a};
    endtask

    initial begin
        int sent;
        int got;
        logic        prev_stall;
        logic [35:0] prev_data;

        vecs[0] = '{4'd1, 32'd7,          32'd3,          4'd5,  32'd10};
        vecs[1] = '{4'd1, 32'hFFFF_FFFF,  32'd2,          4'd5,  32'd1};
        vecs[2] = '{4'd2, 32'd9,          32'd20,         4'd9,  32'hFFFF_FFF5};
        vecs[3] = '{4'd2, 32'd5,          32'd5,          4'd9,  32'd0};
        vecs[4] = '{4'd3, 32'h0000_F0F0,  32'h0000_FF00,  4'd10, 32'h0000_F000};
        vecs[5] = '{4'd4, 32'h0000_AAAA,  32'h0000_5555,  4'd11, 32'h0000_FFFF};
        vecs[6] = '{4'd4, 32'hFFFF_0000,  32'h0F0F_0F0F,  4'd11, 32'hF0F0_0F0F};

        // Reset state, with inputs already presented
        cfg_base();
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(2'b11, 4'd1, 32'd1, 32'd1);
        #1;
        chk("rst_in_ready", in_ready, 2'b00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_valid", error_valid, 1'b0);
        chk("rst_err_code", error_code, 16'd0);
        repeat (2) @(negedge clk);
        in_valid = 2'b00;
        rst_n = 1'b1;

        // Single issues through the FU set: result appears two cycles after fire
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            drive(2'b11, vecs[n].tag, vecs[n].a, vecs[n].b);
            #1;
            chk($sformatf("vec%0d_in_ready", n), in_ready, 2'b11);
            @(posedge clk);
            #1;
            in_valid = 2'b00;
            @(negedge clk);
            chk($sformatf("vec%0d_early", n), out_valid, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", n), out_valid, 1'b1);
            chk($sformatf("vec%0d_data", n), out_data, {vecs[n].rtag, vecs[n].res});
        end

        // Back-to-back issues with the output stalled for three cycles
        sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (sent < 4) drive(2'b11, 4'd1, 32'(sent + 1), 32'd100);
            else in_valid = 2'b00;
            out_ready = (c >= 5);
            #1;
            if (c >= 2 && c <= 4) chk($sformatf("stall_in_ready_c%0d", c), in_ready, 2'b00);
            if (prev_stall) begin
                chk($sformatf("stall_hold_valid_c%0d", c), out_valid, 1'b1);
                chk($sformatf("stall_hold_data_c%0d", c), out_data, prev_data);
            end
            if (out_valid[0] && out_ready[0]) begin
                chk($sformatf("b2b_data_%0d", got), out_data, (exp_q.size() > 0) ? exp_q.pop_front() : 36'hBAD);
                got++;
            end
            prev_stall = out_valid[0] && !out_ready[0];
            prev_data  = out_data;
            if (in_ready[0]) begin
                exp_q.push_back({4'd5, 32'(sent + 101)});
                sent++;
            end
        end
        in_valid = 2'b00;
        out_ready = 1'b1;
        chk("b2b_count", got, 4);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Register path: the reader stalls while reg0 is empty
        @(negedge clk);
        cfg_reg();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(2'b11, 4'd2, 32'd20, 32'd0);
            #1;
            chk($sformatf("reg_empty_stall_%0d", c), in_ready, 2'b00);
        end
        @(negedge clk);
        drive(2'b11, 4'd1, 32'd9, 32'd0);
        #1;
        chk("reg_write_fire", in_ready, 2'b11);
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("reg_dest_no_out_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("reg_busy_held", busy, 1'b1);
        drive(2'b11, 4'd2, 32'd20, 32'd0);
        #1;
        chk("reg_read_consume", in_ready, 2'b01);
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("reg_read_valid", out_valid, 1'b1);
        chk("reg_read_data", out_data, {4'd7, 32'd11});
        @(negedge clk);
        chk("reg_idle_busy", busy, 1'b0);

        // Three writes into the depth-2 FIFO: the third retire stalls
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sent < 3) drive(2'b11, 4'd1, 32'(sent + 1), 32'd0);
            else in_valid = 2'b00;
            #1;
            chk($sformatf("full_no_out_%0d", c), out_valid, 1'b0);
            if (in_ready[0]) sent++;
        end
        in_valid = 2'b00;
        chk("full_sent", sent, 3);
        chk("full_busy", busy, 1'b1);

        // Drain in FIFO order: 20-1, 20-2, 20-3
        exp_q.push_back({4'd7, 32'd19});
        exp_q.push_back({4'd7, 32'd18});
        exp_q.push_back({4'd7, 32'd17});
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            if (sent < 3) drive(2'b01, 4'd2, 32'd20, 32'd0);
            else in_valid = 2'b00;
            #1;
            if (out_valid[0]) begin
                chk($sformatf("drain_%0d", got), out_data, (exp_q.size() > 0) ? exp_q.pop_front() : 36'hBAD);
                got++;
            end
            if (in_ready[0]) sent++;
        end
        in_valid = 2'b00;
        chk("drain_count", got, 3);
        @(negedge clk);
        chk("drain_busy", busy, 1'b0);
        chk("no_err_yet", error_valid, 1'b0);

        // Duplicate tag, then a no-match that must not overwrite it
        cfg_base();
        cfg_data[67:51] = mk(1, 4'd3, 2'd3, 0, 0, 0, 0, 4'd11);
        @(negedge clk);
        chk("dup_valid", error_valid, 1'b1);
        chk("dup_code", error_code, E_DUP);
        drive(2'b11, 4'd9, 32'd1, 32'd1);
        #1;
        chk("nomatch_no_fire", in_ready, 2'b00);
        @(negedge clk);
        chk("dup_kept", error_code, E_DUP);
        in_valid = 2'b00;

        // No match on a clean configuration
        cfg_base();
        do_reset();
        #1;
        chk("clean_after_reset", error_valid, 1'b0);
        drive(2'b11, 4'd9, 32'd1, 32'd1);
        @(negedge clk);
        in_valid = 2'b00;
        chk("nomatch_code", error_code, E_NOMATCH);
        chk("nomatch_no_out", out_valid, 1'b0);

        // Register destination with a non-zero result tag
        cfg_data[67:51] = mk(1, 4'd4, 2'd3, 0, 0, 1, 0, 4'd3);
        do_reset();
        @(negedge clk);
        chk("regtag_code", error_code, E_REG_TAG);

        // Reset with two items in flight
        cfg_base();
        do_reset();
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(2'b11, 4'd1, 32'(c), 32'd1);
            #1;
            if (in_ready[0]) sent++;
        end
        chk("inflight_sent", sent, 2);
        chk("inflight_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_in_ready", in_ready, 2'b00);
        chk("async_busy", busy, 1'b0);
        in_valid = 2'b00;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid_%0d", c), out_valid, 1'b0);
            chk($sformatf("post_rst_busy_%0d", c), busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
